// File: rtl/tinyodin_obi_loader.sv
// tinyODIN OBI loader: 2-D burst write sequencer feeding the tinyODIN
// OBI slave (spike / neuron / synapse / control regions).
//   CLK, RSTN        clock, synchronous active-low reset
//   cmd_*            burst command (region, base, rows, row_len, stride,
//                    stream/constant select, fill word), valid/ready
//   data_*           write-data stream, valid/ready
//   obi_master_*     flattened OBI request (req/we/be/addr/wdata) and
//                    response (gnt/rvalid)
//   busy_o, done_o   command in progress, one-cycle completion pulse
module tinyodin_obi_loader #(
  parameter int MAX_OUTST = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_region_i,
  input  logic [12:0] cmd_base_i,
  input  logic [8:0]  cmd_rows_i,
  input  logic [5:0]  cmd_row_len_i,
  input  logic [12:0] cmd_stride_i,
  input  logic        cmd_stream_i,
  input  logic [31:0] cmd_fill_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        data_ready_o,
  output logic        obi_master_req_o,
  output logic        obi_master_we_o,
  output logic [3:0]  obi_master_be_o,
  output logic [31:0] obi_master_addr_o,
  output logic [31:0] obi_master_wdata_o,
  input  logic        obi_master_gnt_i,
  input  logic        obi_master_rvalid_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic [1:0]    r_region;
  logic [5:0]    r_row_len;
  logic [12:0]   r_stride;
  logic          r_stream;
  logic [31:0]   r_fill;
  logic [12:0]   r_row_start;
  logic [5:0]    r_col;
  logic [8:0]    r_rows_left;
  logic          r_more;
  logic [CW-1:0] r_outst;
  logic          r_req;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  logic          w_idle;
  logic          w_acc;
  logic          w_empty;
  logic          w_gnt;
  logic          w_free;
  logic          w_room;
  logic          w_src;
  logic          w_load;
  logic          w_last_col;
  logic [CW-1:0] w_outst_nxt;
  logic [12:0]   w_start;
  logic [12:0]   w_stride;
  logic [5:0]    w_col;
  logic [5:0]    w_len;
  logic [8:0]    w_rows;
  logic [1:0]    w_region;
  logic [12:0]   w_idx;
  logic [12:0]   w_midx;
  logic [31:0]   w_addr;
  logic [31:0]   w_data;

  assign w_idle  = (r_state == S_IDLE);
  assign w_acc   = w_idle & cmd_valid_i & r_cmd_ready;
  assign w_empty = (cmd_rows_i == 9'd0) | (cmd_row_len_i == 6'd0);

  assign w_gnt  = r_req & obi_master_gnt_i;
  assign w_free = ~r_req | obi_master_gnt_i;

  assign w_outst_nxt = r_outst + CW'(w_gnt)
                     - CW'(obi_master_rvalid_i);
  // Loading only when the post-grant count is below the limit
  // guarantees the loaded word can be granted without overflow.
  assign w_room = (w_outst_nxt < MAX_C);

  assign w_src = (r_state == S_ISSUE) & w_free & r_more & w_room;
  assign data_ready_o = w_src & r_stream;

  // Constant bursts load word 0 directly at command accept.
  assign w_load = (w_src & (~r_stream | data_valid_i))
                | (w_acc & ~cmd_stream_i & ~w_empty);

  assign w_start  = w_idle ? cmd_base_i    : r_row_start;
  assign w_stride = w_idle ? cmd_stride_i  : r_stride;
  assign w_col    = w_idle ? 6'd0          : r_col;
  assign w_len    = w_idle ? cmd_row_len_i : r_row_len;
  assign w_rows   = w_idle ? cmd_rows_i    : r_rows_left;
  assign w_region = w_idle ? cmd_region_i  : r_region;

  assign w_idx      = w_start + {7'd0, w_col};
  assign w_last_col = (w_col == (w_len - 6'd1));

  always_comb begin
    w_midx = 13'd0;
    unique case (w_region)
      2'b00: w_midx = {7'd0, w_idx[5:0]};
      2'b01: w_midx = {5'd0, w_idx[7:0]};
      2'b10: w_midx = w_idx;
      2'b11: w_midx = 13'd0;
    endcase
  end

  assign w_addr = {10'd0, w_region, 20'd0}
                | {17'd0, w_midx, 2'b00};

  assign w_data = w_idle   ? cmd_fill_i :
                  r_stream ? data_i     : r_fill;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_region    <= 2'd0;
      r_row_len   <= 6'd0;
      r_stride    <= 13'd0;
      r_stream    <= 1'b0;
      r_fill      <= 32'd0;
      r_row_start <= 13'd0;
      r_col       <= 6'd0;
      r_rows_left <= 9'd0;
      r_more      <= 1'b0;
      r_outst     <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_outst <= w_outst_nxt;

      if (w_gnt && !w_load) r_req <= 1'b0;

      if (w_acc) begin
        r_region    <= cmd_region_i;
        r_row_len   <= cmd_row_len_i;
        r_stride    <= cmd_stride_i;
        r_stream    <= cmd_stream_i;
        r_fill      <= cmd_fill_i;
        r_row_start <= cmd_base_i;
        r_col       <= 6'd0;
        r_rows_left <= cmd_rows_i;
        r_more      <= ~w_empty;
      end

      if (w_load) begin
        r_req   <= 1'b1;
        r_we    <= 1'b1;
        r_be    <= 4'hF;
        r_addr  <= w_addr;
        r_wdata <= w_data;
        if (w_last_col) begin
          r_col       <= 6'd0;
          r_row_start <= w_start + w_stride;
          r_rows_left <= w_rows - 9'd1;
          r_more      <= (w_rows != 9'd1);
        end else begin
          r_col       <= w_col + 6'd1;
          r_row_start <= w_start;
          r_rows_left <= w_rows;
          r_more      <= 1'b1;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_acc) begin
            r_cmd_ready <= 1'b0;
            r_state     <= w_empty ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_gnt && !r_more) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_outst_nxt == '0) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o        = r_cmd_ready;
  assign obi_master_req_o   = r_req;
  assign obi_master_we_o    = r_we;
  assign obi_master_be_o    = r_be;
  assign obi_master_addr_o  = r_addr;
  assign obi_master_wdata_o = r_wdata;
  assign busy_o             = (r_state != S_IDLE);
  assign done_o             = (r_state == S_DONE);

endmodule

// File: tb/tb_tinyodin_obi_loader.sv
// Bench for tinyodin_obi_loader: random OBI slave timing and stream
// data, checked against a queue model of the 2-D burst word order.
module tb_tinyodin_obi_loader;

  localparam int MAXO = 4;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_region;
  logic [12:0] cmd_base;
  logic [8:0]  cmd_rows;
  logic [5:0]  cmd_len;
  logic [12:0] cmd_stride;
  logic        cmd_stream;
  logic [31:0] cmd_fill;
  logic        dvalid;
  logic [31:0] dword;
  logic        dready;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] sq[$];
  int          due_q[$];
  logic [31:0] g_first, g_14, g_last;

  always #5 clk = ~clk;

  tinyodin_obi_loader #(.MAX_OUTST(MAXO)) dut (
    .CLK                 (clk),
    .RSTN                (rstn),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_region_i        (cmd_region),
    .cmd_base_i          (cmd_base),
    .cmd_rows_i          (cmd_rows),
    .cmd_row_len_i       (cmd_len),
    .cmd_stride_i        (cmd_stride),
    .cmd_stream_i        (cmd_stream),
    .cmd_fill_i          (cmd_fill),
    .data_valid_i        (dvalid),
    .data_i              (dword),
    .data_ready_o        (dready),
    .obi_master_req_o    (req),
    .obi_master_we_o     (we),
    .obi_master_be_o     (be),
    .obi_master_addr_o   (addr),
    .obi_master_wdata_o  (wdata),
    .obi_master_gnt_i    (gnt),
    .obi_master_rvalid_i (rvalid),
    .busy_o              (busy),
    .done_o              (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0]  rg,
                         input logic [12:0] base,
                         input logic [8:0]  rows,
                         input logic [5:0]  len,
                         input logic [12:0] stride,
                         input logic        st,
                         input logic [31:0] fill,
                         input int          bp,
                         input int          abort_at);
    int nexp, sidx, out, maxo, ngr, acc, done_it, last_rv, gap;
    int dbad;
    bit hold, fin, empty;
    logic [31:0] ha, hd, w;
    exp_a.delete();
    exp_d.delete();
    sq.delete();
    due_q.delete();
    for (int r = 0; r < int'(rows); r++) begin
      for (int j = 0; j < int'(len); j++) begin
        int unsigned idx, m;
        idx = (int'(base) + r * int'(stride) + j) % 8192;
        case (rg)
          2'd0:    m = idx % 64;
          2'd1:    m = idx % 256;
          2'd2:    m = idx;
          default: m = 0;
        endcase
        exp_a.push_back((32'(rg) << 20) + 32'(m) * 4);
        w = st ? $urandom : fill;
        if (st) sq.push_back(w);
        exp_d.push_back(w);
      end
    end
    nexp = exp_a.size();
    empty = (nexp == 0);
    sidx = 0; out = 0; maxo = 0; ngr = 0; gap = 0; dbad = 0;
    acc = -1; done_it = -1; last_rv = -1;
    hold = 0; fin = 0; ha = '0; hd = '0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at) return;
      if (acc >= 0 && done) begin
        done_it = k;
        fin = 1;
        break;
      end
      if (hold) begin
        chk("hold_req", req, 1);
        chk("hold_addr", addr, ha);
        chk("hold_wdata", wdata, hd);
      end
      if (!st && dready) dbad++;
      cmd_valid  = (acc < 0);
      cmd_region = rg;
      cmd_base   = base;
      cmd_rows   = rows;
      cmd_len    = len;
      cmd_stride = stride;
      cmd_stream = st;
      cmd_fill   = fill;
      if (bp != 0 && gap > 0) begin
        gnt = 1'b0;
        gap--;
      end else begin
        gnt = 1'b1;
        if (bp != 0 && $urandom_range(0, 2) == 0)
          gap = $urandom_range(1, 5);
      end
      rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= k) begin
        void'(due_q.pop_front());
        rvalid = 1'b1;
        out--;
        last_rv = k;
      end
      if (req && gnt) begin
        if (ngr == 0) g_first = addr;
        if (ngr == 13) g_14 = addr;
        g_last = addr;
        ngr++;
        chk("we_be", {27'd0, we, be}, 32'h1F);
        if (exp_a.size() > 0) begin
          chk("addr", addr, exp_a.pop_front());
          chk("wdata", wdata, exp_d.pop_front());
        end
        out++;
        if (out > maxo) maxo = out;
        due_q.push_back(k + ((bp != 0) ? 3 : 1));
      end
      hold = req && !gnt;
      ha = addr;
      hd = wdata;
      dvalid = st && (sidx < sq.size())
            && (bp == 0 || $urandom_range(0, 3) != 0);
      dword = dvalid ? sq[sidx] : $urandom;
      #1;
      if (acc < 0 && cmd_valid && cmd_ready) acc = k;
      if (dvalid && dready) sidx++;
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    dvalid = 1'b0;
    cmd_valid = 1'b0;
    chk("finished", fin, 1);
    chk("nwrites", ngr, nexp);
    chk("outst_max", maxo <= MAXO, 1);
    chk("outst_end", out, 0);
    chk("dready_const", dbad, 0);
    if (st) chk("stream_used", sidx, sq.size());
    if (empty) chk("done_lat", done_it - acc, 1);
    else chk("done_lat", done_it - last_rv, 1);
    if (bp == 0 && !empty)
      chk("thru", done_it - acc, nexp + (st ? 3 : 2));
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_region = '0;
    cmd_base = '0;
    cmd_rows = '0;
    cmd_len = '0;
    cmd_stride = '0;
    cmd_stream = 1'b0;
    cmd_fill = '0;
    dvalid = 1'b0;
    dword = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    g_first = '0;
    g_14 = '0;
    g_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_be", be, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_dready", dready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_cmd(2'd1, 13'(32 * i), 9'd1, 6'd32, 13'd0,
              1'b0, 32'h0015_E000, 0, 0);
      if (i == 0) chk("neu_first", g_first, 32'h0010_0000);
    end
    chk("neu_last", g_last, 32'h0010_03FC);

    run_cmd(2'd2, 13'd18, 9'd144, 6'd13, 13'd32,
            1'b1, 32'd0, 0, 0);
    chk("syn_first", g_first, 32'h0020_0048);
    chk("syn_14th", g_14, 32'h0020_00C8);
    chk("syn_last", g_last, 32'h0020_47F8);

    run_cmd(2'd2, 13'd100, 9'd8, 6'd9, 13'd40,
            1'b1, 32'd0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 13'($urandom),
              9'($urandom_range(0, 6)), 6'($urandom_range(0, 12)),
              13'($urandom), 1'($urandom_range(0, 1)),
              $urandom, 1, 0);
    end

    run_cmd(2'd3, 13'd77, 9'd1, 6'd1, 13'd0,
            1'b0, 32'hFF00_0400, 0, 0);
    chk("ctrl_addr", g_first, 32'h0030_0000);

    run_cmd(2'd0, 13'd62, 9'd1, 6'd4, 13'd0,
            1'b0, 32'h1234_5678, 0, 0);
    chk("wrap_first", g_first, 32'h0000_00F8);
    chk("wrap_last", g_last, 32'h0000_0004);

    run_cmd(2'd1, 13'd3, 9'd0, 6'd5, 13'd1,
            1'b0, 32'h1, 0, 0);
    run_cmd(2'd2, 13'd3, 9'd5, 6'd0, 13'd1,
            1'b1, 32'h1, 0, 0);

    run_cmd(2'd2, 13'd18, 9'd144, 6'd13, 13'd32,
            1'b1, 32'd0, 1, 40);
    rstn = 1'b0;
    gnt = 1'b0;
    rvalid = 1'b0;
    dvalid = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    run_cmd(2'd0, 13'd5, 9'd3, 6'd3, 13'd10,
            1'b1, 32'd0, 1, 0);
    run_cmd(2'd1, 13'd250, 9'd2, 6'd5, 13'd3,
            1'b0, 32'hCAFE_0001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
